// File: rtl/stepper_pulse_gen.sv
// STEP/DIR pulse generator: accumulates signed tick deltas into a pending count
// and paces STEP pulses with pulse-width, period, DIR-setup and end-stop rules.
module stepper_pulse_gen #(
    parameter int PULSE_HIGH   = 100,
    parameter int PULSE_PERIOD = 250,
    parameter int DIR_SETUP    = 50,
    parameter int MAX_PENDING  = 4000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sync_sim_clock,
    input  logic signed [15:0] delta_steps,
    input  logic               end_left,
    input  logic               end_right,
    output logic               step,
    output logic               dir,
    output logic signed [15:0] step_count,
    output logic signed [16:0] pending,
    output logic               busy,
    output logic               overrun
);

    localparam int CNT_MAX = (PULSE_PERIOD > DIR_SETUP) ? PULSE_PERIOD : DIR_SETUP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]         HIGH_LOAD  = CW'(PULSE_HIGH);
    localparam logic [CW-1:0]         LOW_LOAD   = CW'(PULSE_PERIOD - PULSE_HIGH);
    localparam logic [CW-1:0]         SETUP_LOAD = CW'(DIR_SETUP);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic signed [18:0]    MAX_P      = 19'(MAX_PENDING);
    localparam logic signed [18:0]    MIN_P      = -19'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            sync_q;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [15:0]    count_q, count_d;
    logic signed [16:0]    pend_q, pend_d;
    logic                  overrun_q, overrun_d;

    logic                  tick_edge;
    logic                  issue;
    logic                  clear;
    logic                  want_pos;
    logic                  pend_zero;
    logic                  blocked;
    logic signed [18:0]    inc_w, dec_w, sum_w;

    // Bits [1:0] synchronise the tick, bit [2] holds history for edge detect.
    // They reset high so an input already high at release is not seen as an edge.
    assign tick_edge = sync_q[1] & ~sync_q[2];

    assign want_pos  = ~pend_q[16];
    assign pend_zero = (pend_q == '0);
    assign blocked   = want_pos ? end_left : end_right;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!pend_zero) begin
                    if (blocked) begin
                        clear = 1'b1;
                    end else if (want_pos != dir_q) begin
                        dir_d   = want_pos;
                        cnt_d   = SETUP_LOAD;
                        state_d = S_SETUP;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_ONE) begin
                    if (pend_zero || (want_pos != dir_q)) begin
                        state_d = S_IDLE;
                    end else if (blocked) begin
                        clear   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HIGH: begin
                if (cnt_q == CNT_ONE) begin
                    step_d  = 1'b0;
                    cnt_d   = LOW_LOAD;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            step_d  = 1'b1;
            cnt_d   = HIGH_LOAD;
            state_d = S_HIGH;
        end
    end

    // Tick and step issue in the same cycle both apply; wide sum avoids wrap before clamping.
    always_comb begin
        inc_w     = tick_edge ? {{3{delta_steps[15]}}, delta_steps} : 19'sd0;
        dec_w     = issue ? (dir_q ? 19'sd1 : -19'sd1) : 19'sd0;
        sum_w     = {{2{pend_q[16]}}, pend_q} + inc_w - dec_w;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (issue) begin
            count_d = count_q + (dir_q ? 16'sd1 : -16'sd1);
        end
        if (clear) begin
            pend_d = '0;
        end else if (sum_w > MAX_P) begin
            pend_d    = MAX_P[16:0];
            overrun_d = 1'b1;
        end else if (sum_w < MIN_P) begin
            pend_d    = MIN_P[16:0];
            overrun_d = 1'b1;
        end else begin
            pend_d = sum_w[16:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sync_q    <= 3'b111;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[1:0], sync_sim_clock};
            step_q    <= step_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign step_count = count_q;
    assign pending    = pend_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule
